reg_file: RTL



---
 rtl/reg_file.sv | 77 +++++++
 1 files changed

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- architectural register file for the single-cycle RISC-V datapath
//
// Two combinational read ports (rs1/rs2) and one synchronous write port (rd).
// Entry 0 is hardwired to zero. Register x10 (a0) is exported for debug.
//
// Ports:
//   clk    in   1           system clock, writes on rising edge
//   rst_n  in   1           asynchronous active-low reset, clears all entries
//   AD1    in   ADDR_WIDTH  read address port 1 (rs1)
//   AD2    in   ADDR_WIDTH  read address port 2 (rs2)
//   AD3    in   ADDR_WIDTH  write address (rd)
//   WE3    in   1           write enable
//   WD3    in   DATA_WIDTH  write data
//   RD1    out  DATA_WIDTH  read data port 1 (ALU operand 1)
//   RD2    out  DATA_WIDTH  read data port 2 (operand-2 mux)
//   a0     out  DATA_WIDTH  stored contents of x10, never bypassed
//
// Parameters:
//   BYPASS = 1 forwards same-cycle write data to a matching read port.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A write is effective only to a non-zero address; entry 0 stays zero.
  logic wr_en;
  assign wr_en = WE3 && (AD3 != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[AD3] <= WD3;
    end
  end

  // Forwarding is also gated by rst_n so that a write attempted during
  // reset cannot leak onto the read ports while they must read zero.
  logic fwd1, fwd2;
  assign fwd1 = BYPASS && rst_n && wr_en && (AD1 == AD3);
  assign fwd2 = BYPASS && rst_n && wr_en && (AD2 == AD3);

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (AD1 != '0) begin
      RD1 = fwd1 ? WD3 : mem[AD1];
    end
    if (AD2 != '0) begin
      RD2 = fwd2 ? WD3 : mem[AD2];
    end
  end

  assign a0 = mem[A0_IDX];

endmodule
